candy_seq: RTL and testbench
============================

Name: candy_seq

Overview:
- Parametrised multi-cycle control sequencer for the candy core.
- Owns the PC and steps each instruction through fetch, decode, execute, memory and writeback.
- Generates one-cycle stage enables for the ALU, register file and SRAM write path.
- Generalises the fixed, free-running stage enables with variable-latency SRAM handshakes, timeout detection, branch redirect and halt.

Parameters:
ADDR_W, 8, SRAM/PC address width
DATA_W, 16, instruction/data word width
RESET_PC, 0, PC value after reset
PC_STEP, 1, PC increment per retired non-branch instruction
MEM_TIMEOUT, 15, max consecutive wait cycles for rready before error (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
run  in  1  level; permits starting next instruction
pc  out  ADDR_W  current PC
mem_re  out  1  SRAM read request
mem_raddr  out  ADDR_W  SRAM read address
mem_rdata  in  DATA_W  SRAM read data
mem_rready  in  1  SRAM read data valid
mem_we  out  1  SRAM write strobe (store)
inst  out  DATA_W  latched instruction
inst_valid  out  1  one-cycle pulse in DECODE
is_load  in  1  decoder flag
is_store  in  1  decoder flag
is_halt  in  1  decoder flag
ld_addr  in  ADDR_W  load address
ld_data  out  DATA_W  latched load data
branch_taken  in  1  sampled in WB
branch_target  in  ADDR_W  sampled in WB
ex_en  out  1  ALU enable pulse
rf_we  out  1  register-file write pulse
state  out  3  current state encoding
halted  out  1  high in HALT
err_timeout  out  1  sticky memory-timeout flag
retired_cnt  out  32  retired instructions (see Optional Feature)
stall_cnt  out  32  memory wait cycles (see Optional Feature)

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, pc=RESET_PC.
  - inst, ld_data, counters cleared.
  - All strobes, halted and err_timeout are 0 from the next cycle.
  - Reset mid-instruction aborts it with no writes.
- States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- IDLE: outputs quiet. run=1 -> FETCH.
- FETCH:
  - mem_re=1, mem_raddr=pc.
  - On mem_rready=1, inst<=mem_rdata -> DECODE.
  - mem_rready may be high in the first FETCH cycle (zero wait).
- DECODE:
  - inst_valid=1.
  - Latch is_load, is_store, is_halt into internal flags.
  - Priority: halt > store > load.
  - halt -> HALT; otherwise -> EXEC.
- EXEC: ex_en=1. store or load -> MEM; otherwise -> WB.
- MEM, store: mem_we=1 for exactly one cycle -> WB.
- MEM, load:
  - mem_re=1, mem_raddr=ld_addr.
  - On mem_rready, ld_data<=mem_rdata -> WB.
- WB:
  - rf_we=1 unless store.
  - pc<=branch_taken ? branch_target : pc+PC_STEP, wrapping modulo 2^ADDR_W.
  - Then run ? FETCH : IDLE.
- HALT: halted=1; remains until rst; run ignored.
- Timeout:
  - Wait counter is cleared on entry to FETCH/MEM-load and increments each cycle rready=0.
  - After MEM_TIMEOUT consecutive low cycles -> ERR with err_timeout=1 sticky.
  - rready high in the cycle the limit is reached: ready wins.
  - ERR remains until rst.
- mem_rready outside FETCH/MEM-load is ignored.
- run deasserted mid-instruction: the instruction completes; the sequencer parks in IDLE after WB.
- Latency, zero-wait memory: ALU-only 4 cycles; load/store 5 cycles.

Optional Feature:
CANDY_SEQ_PERF_EN
- Defined:
  - retired_cnt increments on each WB exit.
  - stall_cnt increments each FETCH/MEM-load cycle with rready=0.
  - Both wrap at 2^32 and clear on rst.
- Undefined: both ports tied to 0 and no counter logic is instantiated.
- Port list is identical either way.

Decomposition:
- Shared defines: state encodings (CANDY_SEQ_IDLE..ERR), state width 3, default ADDR_W/DATA_W, aligned with existing SRAMAddrWidth/SRAMDataWidth.
- Natural sub-module: candy_seq_wait, the wait/timeout counter with clear, inc, limit reached and stall pulse; reused by FETCH and MEM-load.

Test Plan:
- Zero-wait ALU op:
  - Stimulus: run=1, rready tied 1, pc=0, no flags.
  - Required: inst_valid cycle 2, ex_en cycle 3, rf_we cycle 4, pc=1 afterwards, FETCH again.
- Load with 3 wait cycles:
  - Stimulus: ld_addr=0x20; rdata=0xBEEF after 3 cycles.
  - Required: mem_raddr=0x20 throughout MEM, ld_data=0xBEEF, rf_we pulse, stall_cnt=3 (PERF_EN).
- Store plus taken branch:
  - Stimulus: store with branch_taken=1, target=0x40.
  - Required: single mem_we pulse, no rf_we, pc=0x40.
- PC wrap:
  - Stimulus: pc=0xFF, ADDR_W=8.
  - Required: pc=0x00 after WB.
- Timeout:
  - Stimulus: rready held 0 in FETCH.
  - Required: state=ERR and err_timeout=1 after 15 wait cycles. A second run with rready rising exactly on cycle 15 completes normally.
- Halt, then reset:
  - Stimulus: is_halt with is_store both 1; then rst mid-FETCH on a later instruction.
  - Required: HALT, halted=1, no mem_we. After rst: IDLE, pc=RESET_PC, all strobes 0.

Source files
------------

// File: rtl/candy_seq_pkg.sv
// -----------------------------------------------------------------------------
// candy_seq_pkg
// Shared definitions for the candy core control sequencer:
//   - default SRAM address/data widths (aligned with SRAMAddrWidth/SRAMDataWidth)
//   - sequencer state width and state encodings CANDY_SEQ_IDLE..CANDY_SEQ_ERR
//   - helper that identifies the states in which the sequencer waits on the SRAM
// -----------------------------------------------------------------------------
package candy_seq_pkg;

  localparam int unsigned SRAMAddrWidth     = 8;
  localparam int unsigned SRAMDataWidth     = 16;
  localparam int unsigned CANDY_SEQ_STATE_W = 3;

  typedef enum logic [CANDY_SEQ_STATE_W-1:0] {
    CANDY_SEQ_IDLE   = 3'd0,
    CANDY_SEQ_FETCH  = 3'd1,
    CANDY_SEQ_DECODE = 3'd2,
    CANDY_SEQ_EXEC   = 3'd3,
    CANDY_SEQ_MEM    = 3'd4,
    CANDY_SEQ_WB     = 3'd5,
    CANDY_SEQ_HALT   = 3'd6,
    CANDY_SEQ_ERR    = 3'd7
  } candy_seq_state_e;

  // True in the states that wait for SRAM read data (FETCH, and MEM for a load).
  function automatic logic is_mem_wait(input candy_seq_state_e st, input logic load);
    return (st == CANDY_SEQ_FETCH) || ((st == CANDY_SEQ_MEM) && load);
  endfunction

endpackage

// File: rtl/candy_seq_wait.sv
// -----------------------------------------------------------------------------
// candy_seq_wait
// Counts consecutive SRAM wait cycles (read requested, rready low) for the
// FETCH and MEM-load states of candy_seq.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   clear_i  in   hold the count at zero (sequencer not waiting on the SRAM)
//   inc_i    in   this cycle is a wait cycle (request pending, rready low)
//   limit_o  out  this wait cycle is the LIMIT-th consecutive one
//   stall_o  out  one pulse per wait cycle
// -----------------------------------------------------------------------------
module candy_seq_wait #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic limit_o,
  output logic stall_o
);

  // The count holds the number of wait cycles already seen, so it only has to
  // reach LIMIT-1: the LIMIT-th low cycle is flagged combinationally.
  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last_s;

  assign at_last_s = (cnt_q == LAST);
  assign limit_o   = inc_i && at_last_s;
  assign stall_o   = inc_i;

  // Next-count logic: clear, count wait cycles, saturate at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_last_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait-count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/candy_seq.sv
// -----------------------------------------------------------------------------
// candy_seq
// Multi-cycle control sequencer for the candy core. Owns the PC and steps each
// instruction through FETCH, DECODE, EXEC, MEM and WB, with variable-latency
// SRAM reads, a wait-cycle timeout (ERR), branch redirect in WB and HALT.
//
// Optional feature macro: CANDY_SEQ_PERF_EN
//   defined   -> retired_cnt_o / stall_cnt_o are live 32-bit wrapping counters
//   undefined -> both ports tied to zero, no counter logic
//
// Ports:
//   clk_i, rst_i                clock, synchronous active-high reset
//   run_i                       permits starting the next instruction
//   pc_o                        current PC
//   mem_re_o, mem_raddr_o       SRAM read request and address
//   mem_rdata_i, mem_rready_i   SRAM read data and data-valid
//   mem_we_o                    SRAM write strobe (store)
//   inst_o, inst_valid_o        latched instruction, pulse in DECODE
//   is_load_i/is_store_i/is_halt_i  decoder flags, sampled in DECODE
//   ld_addr_i, ld_data_o        load address, latched load data
//   branch_taken_i, branch_target_i sampled in WB
//   ex_en_o, rf_we_o            ALU enable pulse, register-file write pulse
//   state_o                     current state encoding
//   halted_o, err_timeout_o     HALT indicator, sticky memory-timeout flag
//   retired_cnt_o, stall_cnt_o  performance counters
// All outputs are registered; strobes are computed from the next state.
// -----------------------------------------------------------------------------
module candy_seq
  import candy_seq_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAMAddrWidth,
  parameter int unsigned DATA_W      = SRAMDataWidth,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         run_i,
  output logic [ADDR_W-1:0]            pc_o,
  output logic                         mem_re_o,
  output logic [ADDR_W-1:0]            mem_raddr_o,
  input  logic [DATA_W-1:0]            mem_rdata_i,
  input  logic                         mem_rready_i,
  output logic                         mem_we_o,
  output logic [DATA_W-1:0]            inst_o,
  output logic                         inst_valid_o,
  input  logic                         is_load_i,
  input  logic                         is_store_i,
  input  logic                         is_halt_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  output logic [DATA_W-1:0]            ld_data_o,
  input  logic                         branch_taken_i,
  input  logic [ADDR_W-1:0]            branch_target_i,
  output logic                         ex_en_o,
  output logic                         rf_we_o,
  output logic [CANDY_SEQ_STATE_W-1:0] state_o,
  output logic                         halted_o,
  output logic                         err_timeout_o,
  output logic [31:0]                  retired_cnt_o,
  output logic [31:0]                  stall_cnt_o
);

  candy_seq_state_e  state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              load_q, load_d;
  logic              store_q, store_d;

  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
  logic              mem_we_q, mem_we_d;
  logic              inst_valid_q, inst_valid_d;
  logic              ex_en_q, ex_en_d;
  logic              rf_we_q, rf_we_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;

  logic              waiting_s;
  logic              wait_inc_s;
  logic              limit_s;
  logic              stall_s;

  assign waiting_s  = is_mem_wait(state_q, load_q);
  assign wait_inc_s = waiting_s && !mem_rready_i;

  candy_seq_wait #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!waiting_s),
    .inc_i   (wait_inc_s),
    .limit_o (limit_s),
    .stall_o (stall_s)
  );

  // Next-state, PC and datapath-latch logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    ld_data_d = ld_data_q;
    load_d    = load_q;
    store_d   = store_q;
    case (state_q)
      CANDY_SEQ_IDLE: begin
        if (run_i) begin
          state_d = CANDY_SEQ_FETCH;
        end else begin
          state_d = CANDY_SEQ_IDLE;
        end
      end
      CANDY_SEQ_FETCH: begin
        // Ready has priority over the timeout on the limit cycle.
        if (mem_rready_i) begin
          inst_d  = mem_rdata_i;
          state_d = CANDY_SEQ_DECODE;
        end else if (limit_s) begin
          state_d = CANDY_SEQ_ERR;
        end else begin
          state_d = CANDY_SEQ_FETCH;
        end
      end
      CANDY_SEQ_DECODE: begin
        // Priority halt > store > load: lower-priority flags are masked.
        store_d = is_store_i && !is_halt_i;
        load_d  = is_load_i && !is_store_i && !is_halt_i;
        if (is_halt_i) begin
          state_d = CANDY_SEQ_HALT;
        end else begin
          state_d = CANDY_SEQ_EXEC;
        end
      end
      CANDY_SEQ_EXEC: begin
        if (store_q || load_q) begin
          state_d = CANDY_SEQ_MEM;
        end else begin
          state_d = CANDY_SEQ_WB;
        end
      end
      CANDY_SEQ_MEM: begin
        if (!load_q) begin
          // Store: the write strobe lasts the single MEM cycle.
          state_d = CANDY_SEQ_WB;
        end else if (mem_rready_i) begin
          ld_data_d = mem_rdata_i;
          state_d   = CANDY_SEQ_WB;
        end else if (limit_s) begin
          state_d = CANDY_SEQ_ERR;
        end else begin
          state_d = CANDY_SEQ_MEM;
        end
      end
      CANDY_SEQ_WB: begin
        // PC arithmetic wraps naturally at ADDR_W bits.
        if (branch_taken_i) begin
          pc_d = branch_target_i;
        end else begin
          pc_d = pc_q + ADDR_W'(PC_STEP);
        end
        if (run_i) begin
          state_d = CANDY_SEQ_FETCH;
        end else begin
          state_d = CANDY_SEQ_IDLE;
        end
      end
      CANDY_SEQ_HALT: state_d = CANDY_SEQ_HALT;
      CANDY_SEQ_ERR:  state_d = CANDY_SEQ_ERR;
      default:        state_d = CANDY_SEQ_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state so they line up with state_o.
  always_comb begin
    mem_re_d     = is_mem_wait(state_d, load_d);
    mem_raddr_d  = '0;
    mem_we_d     = (state_d == CANDY_SEQ_MEM) && store_d;
    inst_valid_d = (state_d == CANDY_SEQ_DECODE);
    ex_en_d      = (state_d == CANDY_SEQ_EXEC);
    rf_we_d      = (state_d == CANDY_SEQ_WB) && !store_d;
    halted_d     = (state_d == CANDY_SEQ_HALT);
    err_d        = err_q || (state_d == CANDY_SEQ_ERR);
    // In MEM-load the address follows ld_addr_i, registered one cycle behind.
    if (state_d == CANDY_SEQ_FETCH) begin
      mem_raddr_d = pc_d;
    end else if ((state_d == CANDY_SEQ_MEM) && load_d) begin
      mem_raddr_d = ld_addr_i;
    end else begin
      mem_raddr_d = '0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= CANDY_SEQ_IDLE;
      pc_q         <= ADDR_W'(RESET_PC);
      inst_q       <= '0;
      ld_data_q    <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_we_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      ex_en_q      <= 1'b0;
      rf_we_q      <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      ld_data_q    <= ld_data_d;
      load_q       <= load_d;
      store_q      <= store_d;
      mem_re_q     <= mem_re_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_we_q     <= mem_we_d;
      inst_valid_q <= inst_valid_d;
      ex_en_q      <= ex_en_d;
      rf_we_q      <= rf_we_d;
      halted_q     <= halted_d;
      err_q        <= err_d;
    end
  end

  assign pc_o          = pc_q;
  assign mem_re_o      = mem_re_q;
  assign mem_raddr_o   = mem_raddr_q;
  assign mem_we_o      = mem_we_q;
  assign inst_o        = inst_q;
  assign inst_valid_o  = inst_valid_q;
  assign ld_data_o     = ld_data_q;
  assign ex_en_o       = ex_en_q;
  assign rf_we_o       = rf_we_q;
  assign state_o       = state_q;
  assign halted_o      = halted_q;
  assign err_timeout_o = err_q;

`ifdef CANDY_SEQ_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_cnt_q;

  // Performance counters: WB always lasts one cycle, so each WB cycle is one retire.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retired_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (state_q == CANDY_SEQ_WB) begin
        retired_q <= retired_q + 32'd1;
      end else begin
        retired_q <= retired_q;
      end
      if (stall_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_cnt_q;
`else
  logic unused_stall_s;
  assign unused_stall_s = stall_s;
  assign retired_cnt_o  = 32'd0;
  assign stall_cnt_o    = 32'd0;
`endif

endmodule

// File: tb/tb_candy_seq.sv
// -----------------------------------------------------------------------------
// tb_candy_seq
// Directed self-checking bench for candy_seq with a reactive SRAM model.
// Each instruction pushes its expected outcome onto a scoreboard queue; the
// entry is popped and compared once the DUT retires (or halts) it.
// -----------------------------------------------------------------------------
module tb_candy_seq;
  import candy_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, run;
  logic [7:0]  pc;
  logic        mem_re, mem_we, mem_rready;
  logic [7:0]  mem_raddr, ld_addr, branch_target;
  logic [15:0] mem_rdata, inst, ld_data;
  logic        inst_valid, is_load, is_store, is_halt;
  logic        branch_taken, ex_en, rf_we, halted, err_timeout;
  logic [2:0]  state;
  logic [31:0] retired_cnt, stall_cnt;

  candy_seq dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .run_i           (run),
    .pc_o            (pc),
    .mem_re_o        (mem_re),
    .mem_raddr_o     (mem_raddr),
    .mem_rdata_i     (mem_rdata),
    .mem_rready_i    (mem_rready),
    .mem_we_o        (mem_we),
    .inst_o          (inst),
    .inst_valid_o    (inst_valid),
    .is_load_i       (is_load),
    .is_store_i      (is_store),
    .is_halt_i       (is_halt),
    .ld_addr_i       (ld_addr),
    .ld_data_o       (ld_data),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .ex_en_o         (ex_en),
    .rf_we_o         (rf_we),
    .state_o         (state),
    .halted_o        (halted),
    .err_timeout_o   (err_timeout),
    .retired_cnt_o   (retired_cnt),
    .stall_cnt_o     (stall_cnt)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    string       tag;
    logic [7:0]  pc;
    logic [15:0] inst;
    logic [15:0] ld;
    int          rf_n;
    int          we_n;
    int          ex_n;
    int          lat;
    logic [2:0]  end_st;
  } exp_t;

  exp_t sb_q[$];

  logic [7:0]  model_pc;
  logic [15:0] model_ld;
  logic [31:0] model_ret;
  logic [31:0] model_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'({mem_re, mem_we, inst_valid, ex_en, rf_we, halted, err_timeout}), 32'd0);
  endtask

  task automatic chk_perf(input string tag);
`ifdef CANDY_SEQ_PERF_EN
    chk({tag, "_retired"}, retired_cnt, model_ret);
    chk({tag, "_stall"}, stall_cnt, model_stall);
`else
    chk({tag, "_retired"}, retired_cnt, 32'd0);
    chk({tag, "_stall"}, stall_cnt, 32'd0);
`endif
  endtask

  // Runs one instruction starting from an observed FETCH cycle. fw/mw are the
  // SRAM wait cycles before rready in FETCH and MEM-load. rready is driven high
  // with junk data in all other states to show it is ignored there.
  task automatic run_instr(input string tag, input logic ld, input logic st, input logic hl,
                           input logic [15:0] iw, input int fw, input int mw,
                           input logic [15:0] ldv, input logic [7:0] la,
                           input logic br, input logic [7:0] tgt, input logic drop_run);
    exp_t e, got;
    int cyc, fcnt, mcnt, iv_c, ex_c, we_n, rf_n, ex_n, bad;
    logic done;
    e.tag  = tag;
    e.inst = iw;
    if (hl) begin
      e.pc = model_pc; e.ld = model_ld; e.rf_n = 0; e.we_n = 0; e.ex_n = 0;
      e.lat = 3 + fw; e.end_st = 3'd6;
    end else begin
      e.pc   = br ? tgt : model_pc + 8'd1;
      e.ld   = (ld && !st) ? ldv : model_ld;
      e.rf_n = st ? 0 : 1;
      e.we_n = st ? 1 : 0;
      e.ex_n = 1;
      e.lat  = 4 + fw + ((ld || st) ? (1 + (st ? 0 : mw)) : 0);
      e.end_st = drop_run ? 3'd0 : 3'd1;
    end
    sb_q.push_back(e);

    is_load = ld; is_store = st; is_halt = hl; ld_addr = la;
    branch_taken = br; branch_target = tgt;
    cyc = 0; fcnt = 0; mcnt = 0; iv_c = 0; ex_c = 0; we_n = 0; rf_n = 0; ex_n = 0; bad = 0;
    done = 1'b0;
    while (!done && cyc < 80) begin
      cyc++;
      if (inst_valid) iv_c = cyc;
      if (ex_en) begin ex_c = cyc; ex_n++; end
      if (mem_we) we_n++;
      if (rf_we) rf_n++;
      case (state)
        3'd1: begin
          if (!mem_re || mem_raddr !== model_pc) bad++;
          if (fcnt < fw) begin mem_rready = 1'b0; fcnt++; end
          else begin mem_rready = 1'b1; mem_rdata = iw; end
        end
        3'd4: begin
          if (ld && !st) begin
            if (!mem_re || mem_raddr !== la) bad++;
            if (mcnt < mw) begin mem_rready = 1'b0; mcnt++; end
            else begin mem_rready = 1'b1; mem_rdata = ldv; end
          end else begin
            mem_rready = 1'b1; mem_rdata = 16'hDEAD;
          end
        end
        3'd5:         begin mem_rready = 1'b1; mem_rdata = 16'hDEAD; done = 1'b1; end
        3'd6, 3'd7:   begin mem_rready = 1'b0; done = 1'b1; end
        default:      begin mem_rready = 1'b1; mem_rdata = 16'hDEAD; end
      endcase
      if (drop_run && cyc == 2) run = 1'b0;
      if (state != 3'd6 && state != 3'd7) tick();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);

    got = sb_q.pop_front();
    chk({got.tag, "_pc"}, 32'(pc), 32'(got.pc));
    chk({got.tag, "_inst"}, 32'(inst), 32'(got.inst));
    chk({got.tag, "_ld_data"}, 32'(ld_data), 32'(got.ld));
    chk({got.tag, "_rf_we_n"}, rf_n, got.rf_n);
    chk({got.tag, "_mem_we_n"}, we_n, got.we_n);
    chk({got.tag, "_ex_en_n"}, ex_n, got.ex_n);
    chk({got.tag, "_latency"}, cyc, got.lat);
    chk({got.tag, "_end_state"}, 32'(state), 32'(got.end_st));
    chk({got.tag, "_raddr_bad"}, bad, 0);
    chk({got.tag, "_iv_cycle"}, iv_c, 2 + fw);
    if (!hl) chk({got.tag, "_ex_cycle"}, ex_c, 3 + fw);

    model_pc    = e.pc;
    model_ld    = e.ld;
    model_ret   = model_ret + (hl ? 32'd0 : 32'd1);
    model_stall = model_stall + 32'(fw) + ((ld && !st) ? 32'(mw) : 32'd0);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_rready = 1'b0; mem_rdata = 16'h0000;
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; ld_addr = 8'h00;
    branch_taken = 1'b0; branch_target = 8'h00;
    model_pc = 8'h00; model_ld = 16'h0000; model_ret = 32'd0; model_stall = 32'd0;

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_ld_data", 32'(ld_data), 32'd0);
    chk_quiet("rst_strobes");
    chk_perf("rst");
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    // Zero-wait ALU op, load with 3 wait cycles, store with taken branch
    run = 1'b1;
    tick();
    chk("start_fetch", 32'(state), 32'd1);
    run_instr("alu", 1'b0, 1'b0, 1'b0, 16'h1234, 0, 0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    run_instr("load", 1'b1, 1'b0, 1'b0, 16'h2001, 0, 3, 16'hBEEF, 8'h20, 1'b0, 8'h00, 1'b0);
    chk_perf("after_load");
    run_instr("store_br", 1'b0, 1'b1, 1'b0, 16'h3002, 2, 0, 16'h0000, 8'h00, 1'b1, 8'h40, 1'b0);

    // PC wrap, with run dropped mid-instruction
    run_instr("br_ff", 1'b0, 1'b0, 1'b0, 16'h4003, 0, 0, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b0);
    run_instr("wrap", 1'b0, 1'b0, 1'b0, 16'h4004, 0, 0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b1);
    tick(); tick();
    chk("park_idle", 32'(state), 32'd0);
    chk_quiet("park_strobes");
    chk_perf("after_wrap");

    // Timeout: rready held low for MEM_TIMEOUT FETCH cycles
    is_load = 1'b0; is_store = 1'b0; is_halt = 1'b0; branch_taken = 1'b0;
    run = 1'b1;
    tick();
    chk("to_fetch", 32'(state), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      mem_rready = 1'b0;
      tick();
      if (i == 14) chk("to_fetch14", 32'(state), 32'd1);
    end
    chk("to_err_state", 32'(state), 32'd7);
    chk("to_err_flag", 32'(err_timeout), 32'd1);
    model_stall = model_stall + 32'd15;
    mem_rready = 1'b1; mem_rdata = 16'h5555;
    tick(); tick(); tick();
    chk("err_sticky", 32'({state, err_timeout, halted, mem_re}), 32'({3'd7, 1'b1, 1'b0, 1'b0}));
    chk_perf("at_err");

    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("err_rst", 32'({state, err_timeout, pc}), 32'({3'd0, 1'b0, 8'h00}));
    model_pc = 8'h00; model_ld = 16'h0000; model_ret = 32'd0; model_stall = 32'd0;
    chk_perf("after_err_rst");

    // rready rises exactly on the last allowed FETCH cycle: completes normally
    run = 1'b1;
    tick();
    run_instr("wait14", 1'b0, 1'b0, 1'b0, 16'h6006, 14, 0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("wait14_no_err", 32'(err_timeout), 32'd0);
    chk_perf("after_wait14");

    // Halt with store also flagged: halt wins, no write
    run_instr("halt", 1'b0, 1'b1, 1'b1, 16'h5005, 0, 0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0);
    mem_rready = 1'b1;
    tick(); tick(); tick();
    chk("halt_hold", 32'({state, halted, mem_we}), 32'({3'd6, 1'b1, 1'b0}));

    // Reset, start a new instruction, then reset again mid-FETCH
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0; run = 1'b1; is_halt = 1'b0; is_store = 1'b0;
    tick();
    chk("mid_fetch", 32'(state), 32'd1);
    mem_rready = 1'b0;
    tick(); tick();
    chk("mid_fetch_wait", 32'(state), 32'd1);
    rst = 1'b1; run = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_pc", 32'(pc), 32'd0);
    chk("abort_inst", 32'(inst), 32'd0);
    chk_quiet("abort_strobes");
    tick();
    chk("abort_idle", 32'(state), 32'd0);
    model_ret = 32'd0; model_stall = 32'd0;
    chk_perf("abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
